vga_vram_tiled: RTL and testbench
=================================

Name: vga_vram_tiled

Overview:
Parametrised, single-clock tiled framebuffer video generator.
- Generates VGA-style timing from a pixel-rate clock.
- Fetches one colour byte per tile from a dual-port VRAM at a programmable scroll offset, with wrap-around.
- Expands the RGB332 byte to 8 bits per channel and outputs it.
- The CPU-side port (data_*) writes the VRAM and, optionally, reads it back in the same clock domain.

Parameters:
- C_MAX_H, 800: total pixels per line; h counter runs 0..C_MAX_H-1.
- C_MAX_V, 525: total lines per frame; v counter runs 0..C_MAX_V-1.
- C_WIDTH, 640: active pixels per line.
- C_HEIGHT, 480: active lines.
- C_SYNC_H_START / C_SYNC_H_END, 656 / 752: hsync low for h in [start, end).
- C_SYNC_V_START / C_SYNC_V_END, 490 / 492: vsync low for v in [start, end).
- TILE_SHIFT, 4: tile edge is 2^TILE_SHIFT pixels.
- MAP_W_BITS, 6: log2 of tile-map width.
- MAP_H_BITS, 6: log2 of tile-map height.
- CNT_BITS, 11: width of the h/v counters and viewport sums.

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high.
- data_length  out  32  constant 2^(MAP_W_BITS+MAP_H_BITS).
- data_address  in  32  VRAM word address: {row, col}, col in the low MAP_W_BITS.
- data_din  in  8  write data, RGB332.
- data_dout  out  8  readback data.
- data_we  in  1  write strobe.
- data_oe  in  1  read strobe.
- offset_h  in  32  signed horizontal scroll in pixels.
- offset_v  in  32  signed vertical scroll in pixels.
- vsync  out  1  one-cycle pulse at the start of vertical blanking.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_de  out  1  data enable.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.

Behaviour:
- Reset values: h=0, v=0, latched offsets 0, vga_hs=1, vga_vs=1, vga_de=0, vga_r/g/b=0, vsync=0, data_dout=0. All pipeline registers are cleared.
- Reset asserted mid-frame restarts timing at h=0, v=0 on the next cycle. VRAM contents are not cleared.
- Counters:
  - h increments every cycle and wraps C_MAX_H-1 -> 0.
  - v increments when h wraps and wraps C_MAX_V-1 -> 0.
- Offset latch: offset_h/offset_v are sampled only on the cycle h=0, v=C_HEIGHT, giving tear-free scrolling. That same cycle asserts vsync for exactly 1 cycle.
- Pipeline, 3 cycles from counter state to pins:
  - S1: hp = h + latched_offset_h and vp = v + latched_offset_v, truncated to CNT_BITS (two's complement, so negative offsets wrap).
  - S2: registered VRAM read at address {vp[TILE_SHIFT +: MAP_H_BITS], hp[TILE_SHIFT +: MAP_W_BITS]}. The map wraps toroidally.
  - S3: register the colour outputs.
- Sync alignment: vga_hs, vga_vs and vga_de are computed from h/v and delayed 3 cycles so they align with the colour outputs. vga_de = (h < C_WIDTH) && (v < C_HEIGHT).
- Colour expansion, by bit replication:
  - r = {d[7:5], d[7:5], d[7:6]}
  - g = {d[4:2], d[4:2], d[4:3]}
  - b = {d[1:0] repeated 4 times}
- Blanking: when de=0, r/g/b=0.
- Writes: when data_we=1 and data_address < data_length, VRAM[data_address[11:0] scaled to map bits] is updated on the clk edge. Out-of-range writes are ignored.
- Simultaneous video read and CPU write to the same word: the video side sees the old data on that cycle.

Optional Feature:
Macro: VGA_VRAM_TILED_READBACK_EN.
- Defined:
  - data_oe=1 with an in-range address gives data_dout = VRAM word one cycle later; the value holds until the next data_oe.
  - An out-of-range address gives data_dout = 0.
  - Read and write to the same address on the same cycle returns the old data.
- Undefined: data_dout is tied to 0 and data_oe is ignored. The VRAM is a pure simple-dual-port memory.

Test Plan:
- Timing check: reset 1 cycle, run 2 frames with defaults. Required: hsync low for exactly 96 clocks per line, period 800; vsync pin low for 2 lines, period 525 lines; vsync pulse every 420000 clocks; de high for 640x480 per frame.
- Fill and pixel mapping: write VRAM[i] = i[7:0] for all 4096 words, offsets 0. At screen pixel (x=37, y=20), the pins 3 cycles after h=37, v=20 show byte 0x42 (row 1, col 2): r=0x49, g=0x00, b=0xAA.
- Scroll wrap: set offset_h=-16, offset_v=1024 mid-frame. The new values take effect only after the next h=0, v=480. Screen x=0 then shows map col 63, and v wraps via the 11-bit sum to map row 0.
- Blanking and latency: write VRAM all 0xFF. During h=640..799, r/g/b=0 and de=0. First non-zero r appears exactly 3 cycles after h=0 on an active line.
- Reset mid-frame: assert reset at h=300, v=200 for 1 cycle. Next cycles show h=0, v=0, outputs at reset values, VRAM data intact.
- Readback (with VGA_VRAM_TILED_READBACK_EN): write 0x5A to address 100, then oe on address 100 gives dout=0x5A next cycle. oe on address 5000 gives dout=0. Simultaneous we=0x11 and oe at address 100 gives 0x5A, and the following read gives 0x11.

Source files
------------

// File: rtl/vga_vram_tiled.sv
// vga_vram_tiled: tiled RGB332 framebuffer video generator with scrollable toroidal tile map.
// Optional CPU readback port enabled by defining VGA_VRAM_TILED_READBACK_EN.
module vga_vram_tiled #(
  parameter int C_MAX_H        = 800,
  parameter int C_MAX_V        = 525,
  parameter int C_WIDTH        = 640,
  parameter int C_HEIGHT       = 480,
  parameter int C_SYNC_H_START = 656,
  parameter int C_SYNC_H_END   = 752,
  parameter int C_SYNC_V_START = 490,
  parameter int C_SYNC_V_END   = 492,
  parameter int TILE_SHIFT     = 4,
  parameter int MAP_W_BITS     = 6,
  parameter int MAP_H_BITS     = 6,
  parameter int CNT_BITS       = 11
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] data_length,
  input  logic [31:0] data_address,
  input  logic [7:0]  data_din,
  output logic [7:0]  data_dout,
  input  logic        data_we,
  input  logic        data_oe,
  input  logic [31:0] offset_h,
  input  logic [31:0] offset_v,
  output logic        vsync,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);
  localparam int AW    = MAP_W_BITS + MAP_H_BITS;
  localparam int DEPTH = 1 << AW;
  localparam logic [CNT_BITS-1:0] H_LAST = CNT_BITS'(C_MAX_H - 1);
  localparam logic [CNT_BITS-1:0] V_LAST = CNT_BITS'(C_MAX_V - 1);
  localparam logic [CNT_BITS-1:0] H_ACT  = CNT_BITS'(C_WIDTH);
  localparam logic [CNT_BITS-1:0] V_ACT  = CNT_BITS'(C_HEIGHT);
  localparam logic [CNT_BITS-1:0] HS0    = CNT_BITS'(C_SYNC_H_START);
  localparam logic [CNT_BITS-1:0] HS1    = CNT_BITS'(C_SYNC_H_END);
  localparam logic [CNT_BITS-1:0] VS0    = CNT_BITS'(C_SYNC_V_START);
  localparam logic [CNT_BITS-1:0] VS1    = CNT_BITS'(C_SYNC_V_END);
  logic [7:0] mem [DEPTH];
  logic [CNT_BITS-1:0] h_q, h_d, v_q, v_d, oh_q, oh_d, ov_q, ov_d, hsum, vsum;
  logic [AW-1:0] a_q, a_d;
  logic [7:0] pix_q, pix_d, dout_q, dout_d;
  // sync/de delay lines: bit 2 lines up with the registered colour
  logic [2:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic in_range, latch, unused_bits;
  assign data_length = 32'(DEPTH);
  assign in_range    = data_address < data_length;
  assign latch       = h_q == '0 && v_q == V_ACT;
  assign vsync       = latch;
  assign hsum        = h_q + oh_q;
  assign vsum        = v_q + ov_q;
  assign vga_hs      = hs_q[2];
  assign vga_vs      = vs_q[2];
  assign vga_de      = de_q[2];
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign data_dout   = dout_q;
  always_comb begin
    h_d    = h_q == H_LAST ? '0 : h_q + CNT_BITS'(1);
    v_d    = h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + CNT_BITS'(1);
    oh_d   = latch ? offset_h[CNT_BITS-1:0] : oh_q;
    ov_d   = latch ? offset_v[CNT_BITS-1:0] : ov_q;
    a_d    = {vsum[TILE_SHIFT +: MAP_H_BITS], hsum[TILE_SHIFT +: MAP_W_BITS]};
    pix_d  = mem[a_q];
    hs_d   = {hs_q[1:0], !(h_q >= HS0 && h_q < HS1)};
    vs_d   = {vs_q[1:0], !(v_q >= VS0 && v_q < VS1)};
    de_d   = {de_q[1:0], h_q < H_ACT && v_q < V_ACT};
    rgb_d  = de_q[1] ? {pix_q[7:5], pix_q[7:5], pix_q[7:6],
                        pix_q[4:2], pix_q[4:2], pix_q[4:3],
                        {4{pix_q[1:0]}}} : '0;
`ifdef VGA_VRAM_TILED_READBACK_EN
    dout_d = !data_oe ? dout_q : in_range ? mem[data_address[AW-1:0]] : '0;
`else
    dout_d = '0;
`endif
  end
`ifdef VGA_VRAM_TILED_READBACK_EN
  assign unused_bits = &{1'b0, offset_h, offset_v, hsum, vsum};
`else
  assign unused_bits = &{1'b0, offset_h, offset_v, hsum, vsum, data_oe};
`endif
  always_ff @(posedge clk)
    if (data_we && in_range) mem[data_address[AW-1:0]] <= data_din;
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      oh_q   <= '0;
      ov_q   <= '0;
      a_q    <= '0;
      pix_q  <= '0;
      hs_q   <= '1;
      vs_q   <= '1;
      de_q   <= '0;
      rgb_q  <= '0;
      dout_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      oh_q   <= oh_d;
      ov_q   <= ov_d;
      a_q    <= a_d;
      pix_q  <= pix_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      rgb_q  <= rgb_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_vga_vram_tiled.sv
// tb_vga_vram_tiled: directed checks of timing, tile mapping, scrolling, blanking, reset and readback.
// Uses a reduced raster (100x60 total, 64x40 active) so whole frames stay short.
module tb_vga_vram_tiled;
  localparam int MH = 100, MV = 60, W = 64, HT = 40;
  localparam int HS0 = 70, HS1 = 80, VS0 = 45, VS1 = 47;
  logic clk = 0, reset = 1;
  logic [31:0] data_length, data_address = 0, offset_h = 0, offset_v = 0;
  logic [7:0] data_din = 0, data_dout, vga_r, vga_g, vga_b;
  logic data_we = 0, data_oe = 0, vsync, vga_hs, vga_vs, vga_de;
  int checks = 0, failures = 0;
  int mh = 0, mv = 0;
  typedef struct { int x; int y; logic [7:0] r; logic [7:0] g; logic [7:0] b; logic de; } vec_t;
  vec_t vt[6];

  vga_vram_tiled #(
    .C_MAX_H(MH), .C_MAX_V(MV), .C_WIDTH(W), .C_HEIGHT(HT),
    .C_SYNC_H_START(HS0), .C_SYNC_H_END(HS1), .C_SYNC_V_START(VS0), .C_SYNC_V_END(VS1)
  ) dut (
    .clk(clk), .reset(reset), .data_length(data_length), .data_address(data_address),
    .data_din(data_din), .data_dout(data_dout), .data_we(data_we), .data_oe(data_oe),
    .offset_h(offset_h), .offset_v(offset_v), .vsync(vsync), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_de(vga_de), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // reference raster position, equals the DUT counter state between edges
  always @(posedge clk)
    if (reset) begin
      mh <= 0;
      mv <= 0;
    end else begin
      mh <= (mh == MH - 1) ? 0 : mh + 1;
      if (mh == MH - 1) mv <= (mv == MV - 1) ? 0 : mv + 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic go(input int x, input int y);
    int n = 0;
    @(negedge clk);
    while (!(mh == x && mv == y) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL goto_%0d_%0d: position not reached", x, y);
    end
  endtask

  task automatic pix(input string nm, input int x, input int y,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    go(x + 3, y);
    chk({nm, "_r"}, vga_r, r);
    chk({nm, "_g"}, vga_g, g);
    chk({nm, "_b"}, vga_b, b);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    data_address = a;
    data_din = d;
    data_we = 1;
    @(negedge clk);
    data_we = 0;
  endtask

  task automatic fill(input logic ramp, input logic [7:0] v);
    for (int i = 0; i < 4096; i++) begin
      data_address = i;
      data_din = ramp ? 8'(i) : v;
      data_we = 1;
      @(negedge clk);
    end
    data_we = 0;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_hs"}, vga_hs, 1);
    chk({nm, "_vs"}, vga_vs, 1);
    chk({nm, "_de"}, vga_de, 0);
    chk({nm, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({nm, "_vsync"}, vsync, 0);
    chk({nm, "_dout"}, data_dout, 0);
  endtask

  initial begin
    int hs_bad, vs_bad, de_bad, vp_bad, de_cnt, hs_low, vs_low, vp_cnt, vp_first, vp_last;
    vt[0] = '{x: 0,  y: 0,  r: 8'h00, g: 8'h00, b: 8'h00, de: 1};
    vt[1] = '{x: 64, y: 10, r: 8'h00, g: 8'h00, b: 8'h00, de: 0};
    vt[2] = '{x: 37, y: 20, r: 8'h49, g: 8'h00, b: 8'hAA, de: 1};
    vt[3] = '{x: 20, y: 35, r: 8'h92, g: 8'h00, b: 8'h55, de: 1};
    vt[4] = '{x: 63, y: 39, r: 8'h92, g: 8'h00, b: 8'hFF, de: 1};
    vt[5] = '{x: 10, y: 45, r: 8'h00, g: 8'h00, b: 8'h00, de: 0};

    @(negedge clk);
    check_reset_state("reset");
    chk("data_length", data_length, 4096);
    reset = 0;

    // two frames of sync/de shape against the delayed reference position
    go(3, 0);
    {hs_bad, vs_bad, de_bad, vp_bad, de_cnt, hs_low, vs_low, vp_cnt, vp_first, vp_last} = '0;
    for (int i = 0; i < 2 * MH * MV; i++) begin
      int hd, vd;
      hd = mh >= 3 ? mh - 3 : mh + MH - 3;
      vd = mh >= 3 ? mv : (mv == 0 ? MV - 1 : mv - 1);
      if (vga_hs !== !(hd >= HS0 && hd < HS1)) hs_bad++;
      if (vga_vs !== !(vd >= VS0 && vd < VS1)) vs_bad++;
      if (vga_de !== (hd < W && vd < HT)) de_bad++;
      if (vsync !== (mh == 0 && mv == HT)) vp_bad++;
      if (vga_de === 1'b1) de_cnt++;
      if (vga_hs === 1'b0) hs_low++;
      if (vga_vs === 1'b0) vs_low++;
      if (vsync === 1'b1) begin
        if (vp_cnt == 0) vp_first = i;
        vp_last = i;
        vp_cnt++;
      end
      @(negedge clk);
    end
    chk("hs_shape_errs", hs_bad, 0);
    chk("vs_shape_errs", vs_bad, 0);
    chk("de_shape_errs", de_bad, 0);
    chk("vsync_pulse_errs", vp_bad, 0);
    chk("de_count", de_cnt, 2 * W * HT);
    chk("hs_low_count", hs_low, 2 * MV * (HS1 - HS0));
    chk("vs_low_count", vs_low, 2 * MH * (VS1 - VS0));
    chk("vsync_pulses", vp_cnt, 2);
    chk("vsync_period", vp_last - vp_first, MH * MV);

    // ramp fill, then an out-of-range write that would alias word 1 if not ignored
    fill(1, 0);
    wr(4097, 8'hEE);
    pix("oor_write", 20, 0, 8'h00, 8'h00, 8'h55);
    for (int i = 0; i < 6; i++) begin
      go(vt[i].x + 3, vt[i].y);
      chk($sformatf("vec%0d_r", i), vga_r, vt[i].r);
      chk($sformatf("vec%0d_g", i), vga_g, vt[i].g);
      chk($sformatf("vec%0d_b", i), vga_b, vt[i].b);
      chk($sformatf("vec%0d_de", i), vga_de, vt[i].de);
    end

    // scroll: new offsets wait for the latch at h=0, v=HT
    go(10, 20);
    offset_h = -32'sd16;
    offset_v = 32'd1024;
    pix("scroll_old", 37, 30, 8'h49, 8'h00, 8'hAA);
    go(5, HT);
    offset_h = 0;
    offset_v = 0;
    pix("scroll_x0", 0, 0, 8'h24, 8'hFF, 8'hFF);
    pix("scroll_mid", 37, 20, 8'h49, 8'h00, 8'h55);

    // mid-frame reset while scrolled offsets are still latched
    go(50, 20);
    reset = 1;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 0;
    pix("after_reset", 37, 20, 8'h49, 8'h00, 8'hAA);

    // blanking edges and 3-cycle latency on a solid white screen
    fill(0, 8'hFF);
    go(66, 4);
    chk("last_active_r", vga_r, 8'hFF);
    chk("last_active_de", vga_de, 1);
    go(67, 4);
    chk("first_blank_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("first_blank_de", vga_de, 0);
    go(2, 5);
    chk("pre_line_r", vga_r, 8'h00);
    go(3, 5);
    chk("line_start_r", vga_r, 8'hFF);
    chk("line_start_b", vga_b, 8'hFF);

`ifdef VGA_VRAM_TILED_READBACK_EN
    wr(100, 8'h5A);
    data_address = 100;
    data_oe = 1;
    @(negedge clk);
    data_oe = 0;
    chk("rb_read", data_dout, 8'h5A);
    @(negedge clk);
    chk("rb_hold", data_dout, 8'h5A);
    data_address = 5000;
    data_oe = 1;
    @(negedge clk);
    data_oe = 0;
    chk("rb_oor", data_dout, 8'h00);
    data_address = 100;
    data_din = 8'h11;
    data_we = 1;
    data_oe = 1;
    @(negedge clk);
    data_we = 0;
    chk("rb_rw_old", data_dout, 8'h5A);
    @(negedge clk);
    data_oe = 0;
    chk("rb_rw_new", data_dout, 8'h11);
`else
    data_address = 200;
    data_oe = 1;
    @(negedge clk);
    data_oe = 0;
    chk("no_readback", data_dout, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
